// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first unsigned subtractor: diff = ain - bin with borrow out.
// Start/busy/done handshake, one operation in flight, all outputs registered.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] a_sr_r, a_sr_s;
  logic [WIDTH-1:0] b_sr_r, b_sr_s;
  logic [WIDTH-1:0] r_sr_r, r_sr_s;
  logic             br_r, br_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic [WIDTH-1:0] diff_r, diff_s;
  logic             bo_r, bo_s;
  logic             d_bit_s;

  function automatic logic borrow_next(input logic a, input logic b, input logic bi);
    return (~a & b) | (~(a ^ b) & bi);
  endfunction

  // Next-state, datapath and output decode for the serial sequencer
  always_comb begin
    state_s = state_r;
    a_sr_s  = a_sr_r;
    b_sr_s  = b_sr_r;
    r_sr_s  = r_sr_r;
    br_s    = br_r;
    cnt_s   = cnt_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    diff_s  = diff_r;
    bo_s    = bo_r;
    d_bit_s = a_sr_r[0] ^ b_sr_r[0] ^ br_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          a_sr_s  = ain;
          b_sr_s  = bin;
          r_sr_s  = {WIDTH{1'b0}};
          br_s    = 1'b0;
          cnt_s   = {CW{1'b0}};
          busy_s  = 1'b1;
          state_s = SHIFT;
        end else begin
          busy_s  = 1'b0;
          state_s = IDLE;
        end
      end
      SHIFT: begin
        br_s   = borrow_next(a_sr_r[0], b_sr_r[0], br_r);
        r_sr_s = {d_bit_s, r_sr_r[WIDTH-1:1]};
        a_sr_s = {1'b0, a_sr_r[WIDTH-1:1]};
        b_sr_s = {1'b0, b_sr_r[WIDTH-1:1]};
        cnt_s  = cnt_r + CW'(1);
        busy_s = 1'b1;
        // Last bit: publish the completed result together with the done pulse
        if (cnt_r == LAST_CNT) begin
          diff_s  = r_sr_s;
          bo_s    = br_s;
          done_s  = 1'b1;
          state_s = DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE: begin
        busy_s  = 1'b0;
        state_s = IDLE;
      end
      default: begin
        busy_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State, operand/result shift registers and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      a_sr_r  <= {WIDTH{1'b0}};
      b_sr_r  <= {WIDTH{1'b0}};
      r_sr_r  <= {WIDTH{1'b0}};
      br_r    <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      diff_r  <= {WIDTH{1'b0}};
      bo_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      a_sr_r  <= a_sr_s;
      b_sr_r  <= b_sr_s;
      r_sr_r  <= r_sr_s;
      br_r    <= br_s;
      cnt_r   <= cnt_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      diff_r  <= diff_s;
      bo_r    <= bo_s;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign diff = diff_r;
  assign bo   = bo_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: cycle-level behavioural model plus
// directed literal checks and randomized operations.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] ain;
  logic [WIDTH-1:0] bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bo;

  int n_tests;
  int n_fail;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .ain   (ain),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bo    (bo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: an accepted op occupies WIDTH+1 cycles; done shows in the last one.
  int               m_rem;
  logic [WIDTH:0]   m_pend;
  logic [WIDTH-1:0] m_diff;
  logic             m_bo;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_rem  <= 0;
      m_pend <= '0;
      m_diff <= '0;
      m_bo   <= 1'b0;
    end else if (m_rem == 0) begin
      if (start) begin
        m_rem  <= WIDTH + 1;
        m_pend <= {1'b0, ain} - {1'b0, bin};
      end
    end else begin
      m_rem <= m_rem - 1;
      if (m_rem == 2) {m_bo, m_diff} <= m_pend;
    end
  end

  always @(negedge clk) begin
    n_tests++;
    if (busy !== (m_rem != 0) || done !== (m_rem == 1) || diff !== m_diff || bo !== m_bo) begin
      n_fail++;
      $display("FAIL cycle_cmp t=%0t got busy=%b done=%b diff=%0d bo=%b expected busy=%b done=%b diff=%0d bo=%b",
               $time, busy, done, diff, bo, (m_rem != 0), (m_rem == 1), m_diff, m_bo);
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3 * WIDTH; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout waiting for done", name);
    end
  endtask

  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    ain   = a;
    bin   = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    ain   = $urandom();
    bin   = $urandom();
  endtask

  task automatic directed(input string name, input int a, input int b,
                          input int exp_diff, input int exp_bo);
    bit ok;
    issue(WIDTH'(a), WIDTH'(b));
    wait_done(name, ok);
    if (ok) begin
      check({name, "_diff"}, int'(diff), exp_diff);
      check({name, "_bo"}, int'(bo), exp_bo);
      check({name, "_model"}, int'({m_bo, m_diff}), exp_bo * 256 + exp_diff);
    end
    tick();
  endtask

  initial begin
    bit ok;
    int dones;
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b0;
    start = 1'b0;
    ain   = '0;
    bin   = '0;
    tick();
    tick();
    @(negedge clk);
    check("reset_outputs", int'({busy, done, bo, diff}), 0);
    reset = 1'b1;
    tick();

    directed("op_200_55", 200, 55, 145, 0);
    directed("op_5_10", 5, 10, 251, 1);
    directed("op_0_255", 0, 255, 1, 1);
    directed("op_255_255", 255, 255, 0, 0);

    // start held high: one done every WIDTH+2 cycles
    ain = 8'd100;
    bin = 8'd30;
    start = 1'b1;
    dones = 0;
    for (int i = 0; i < 3 * (WIDTH + 2); i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    start = 1'b0;
    check("held_start_dones", dones, 3);
    check("held_start_diff", int'(diff), 70);
    for (int i = 0; i < WIDTH + 4; i++) tick();

    // second start mid-SHIFT with new operands must be ignored
    issue(8'd200, 8'd55);
    tick();
    tick();
    ain = 8'd7;
    bin = 8'd100;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("midshift", ok);
    if (ok) begin
      check("midshift_diff", int'(diff), 145);
      check("midshift_bo", int'(bo), 0);
    end
    dones = 0;
    for (int i = 0; i < WIDTH + 3; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("midshift_no_second_done", dones, 0);

    // reset in the middle of SHIFT aborts at once
    issue(8'd5, 8'd10);
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b0;
    #1;
    check("abort_outputs", int'({busy, done, bo, diff}), 0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    directed("after_abort", 0, 255, 1, 1);

    // randomized operations, with occasional stray starts while busy
    for (int n = 0; n < 1000; n++) begin
      logic [WIDTH-1:0] a, b;
      logic [WIDTH:0]   expv;
      a = $urandom();
      b = $urandom();
      expv = {1'b0, a} - {1'b0, b};
      issue(a, b);
      if ($urandom_range(3) == 0) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      wait_done("random", ok);
      if (ok) check("random_result", int'({bo, diff}), int'(expv));
      tick();
      for (int g = 0; g < int'($urandom_range(2)); g++) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
